// File: rtl/sd_cmd_serializer_pkg.sv
// SD CMD-line engine shared definitions.
// FSM states, CRC7 polynomial and frame geometry.
package sd_cmd_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    TURN,
    WAIT_START,
    RX,
    FINISH
  } state_t;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int FRAME_BITS = 48;
  localparam int CRC_BITS = 40;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enable.
// Cleared to zero by CLR; CLR wins over EN.
module sd_crc7
  import sd_cmd_serializer_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CLR,
  input  logic       EN,
  input  logic       BIT,
  output logic [6:0] CRC
);

  logic fb;

  assign fb = BIT ^ CRC[6];

  // shift the remainder, folding in the polynomial on feedback
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CRC <= '0;
    end else if (CLR) begin
      CRC <= '0;
    end else if (EN) begin
      CRC <= {CRC[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sd_cmd_serializer.sv
// SD CMD-line command serializer with optional R1/R3/R6/R7 capture.
// Define SD_CMD_RSP_CRC_CHECK_EN to also check the response CRC7.
module sd_cmd_serializer
  import sd_cmd_serializer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TURN_CYCLES    = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SD_CLK,
  input  logic        START,
  input  logic [5:0]  CMD_INDEX,
  input  logic [31:0] CMD_ARG,
  input  logic        RSP_EXPECT,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic        CRC_ERR,
  output logic [5:0]  RSP_INDEX,
  output logic [31:0] RSP_ARG,
  output logic        CMD_O,
  output logic        CMD_OE,
  input  logic        CMD_I
);

  localparam int BCW = $clog2(FRAME_BITS) + 1;
  localparam int TNW = $clog2(TURN_CYCLES) + 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t st;
  logic sd_q;
  logic fall;
  logic rise;
  logic rsp_exp;
  logic accept;
  logic tx_bit;
  logic tx_crc_en;
  logic rx_crc_err;
  logic [6:0] tx_crc;
  logic [CRC_BITS-1:0] tx_sr;
  logic [44:0] rx_sr;
  logic [BCW-1:0] bcnt;
  logic [BCW-1:0] rcnt;
  logic [TNW-1:0] tcnt;
  logic [TOW-1:0] tocnt;

  assign fall = sd_q & ~SD_CLK;
  assign rise = ~sd_q & SD_CLK;
  assign accept = (st == IDLE) & START & ~BUSY;
  assign tx_crc_en = (st == TX) & fall
                   & (bcnt < BCW'(CRC_BITS));

  // SD_CLK history for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sd_q <= 1'b0;
    else        sd_q <= SD_CLK;
  end

  // next frame bit: header/arg, then CRC7, then end bit
  always_comb begin
    tx_bit = 1'b1;
    if (bcnt < BCW'(CRC_BITS)) begin
      tx_bit = tx_sr[CRC_BITS-1];
    end else if (bcnt < BCW'(FRAME_BITS-1)) begin
      tx_bit = tx_crc[3'(BCW'(FRAME_BITS-2) - bcnt)];
    end
  end

  sd_crc7 u_tx_crc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (accept),
    .EN    (tx_crc_en),
    .BIT   (tx_sr[CRC_BITS-1]),
    .CRC   (tx_crc)
  );

`ifdef SD_CMD_RSP_CRC_CHECK_EN
  logic rx_crc_en;
  logic [6:0] rx_crc;

  assign rx_crc_en = rise & (
      ((st == WAIT_START) & ~CMD_I)
    | ((st == RX) & (rcnt < BCW'(CRC_BITS-1))));

  sd_crc7 u_rx_crc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (accept),
    .EN    (rx_crc_en),
    .BIT   (CMD_I),
    .CRC   (rx_crc)
  );

  assign rx_crc_err = (rx_crc != rx_sr[6:0]);
`else
  assign rx_crc_err = 1'b0;
`endif

  // command/response sequencer with registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st        <= IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      TIMEOUT   <= 1'b0;
      CRC_ERR   <= 1'b0;
      RSP_INDEX <= '0;
      RSP_ARG   <= '0;
      CMD_O     <= 1'b1;
      CMD_OE    <= 1'b0;
      rsp_exp   <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bcnt      <= '0;
      rcnt      <= '0;
      tcnt      <= '0;
      tocnt     <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (st)
        IDLE: begin
          if (accept) begin
            tx_sr     <= {2'b01, CMD_INDEX, CMD_ARG};
            rsp_exp   <= RSP_EXPECT;
            TIMEOUT   <= 1'b0;
            CRC_ERR   <= 1'b0;
            RSP_INDEX <= '0;
            RSP_ARG   <= '0;
            BUSY      <= 1'b1;
            bcnt      <= '0;
            st        <= TX;
          end
        end
        TX: begin
          if (fall) begin
            if (bcnt == BCW'(FRAME_BITS)) begin
              CMD_OE <= 1'b0;
              CMD_O  <= 1'b1;
              tcnt   <= '0;
              if (rsp_exp) begin
                st <= TURN;
              end else begin
                DONE <= 1'b1;
                st   <= FINISH;
              end
            end else begin
              CMD_OE <= 1'b1;
              CMD_O  <= tx_bit;
              bcnt   <= bcnt + 1'b1;
              if (bcnt < BCW'(CRC_BITS)) begin
                tx_sr <= {tx_sr[CRC_BITS-2:0], 1'b0};
              end
            end
          end
        end
        TURN: begin
          if (rise) begin
            if (tcnt == TNW'(TURN_CYCLES-1)) begin
              tocnt <= '0;
              st    <= WAIT_START;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        WAIT_START: begin
          if (rise) begin
            if (!CMD_I) begin
              rx_sr <= '0;
              rcnt  <= '0;
              st    <= RX;
            end else if (tocnt == TOW'(TIMEOUT_CYCLES-1)) begin
              TIMEOUT <= 1'b1;
              DONE    <= 1'b1;
              st      <= FINISH;
            end else begin
              tocnt <= tocnt + 1'b1;
            end
          end
        end
        RX: begin
          if (rise) begin
            rx_sr <= {rx_sr[43:0], CMD_I};
            rcnt  <= rcnt + 1'b1;
            if (rcnt == BCW'(FRAME_BITS-2)) begin
              RSP_INDEX <= rx_sr[44:39];
              RSP_ARG   <= rx_sr[38:7];
              CRC_ERR   <= ~CMD_I | rx_crc_err;
              DONE      <= 1'b1;
              st        <= FINISH;
            end
          end
        end
        FINISH: begin
          BUSY <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Self-checking bench for sd_cmd_serializer.
// Frame-level model, SD card responder and per-cycle monitor.
module tb_sd_cmd_serializer;

  logic        CLK;
  logic        RST_N;
  logic        SD_CLK;
  logic        START;
  logic [5:0]  CMD_INDEX;
  logic [31:0] CMD_ARG;
  logic        RSP_EXPECT;
  logic        BUSY;
  logic        DONE;
  logic        TIMEOUT;
  logic        CRC_ERR;
  logic [5:0]  RSP_INDEX;
  logic [31:0] RSP_ARG;
  logic        CMD_O;
  logic        CMD_OE;
  logic        CMD_I;

  sd_cmd_serializer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SD_CLK     (SD_CLK),
    .START      (START),
    .CMD_INDEX  (CMD_INDEX),
    .CMD_ARG    (CMD_ARG),
    .RSP_EXPECT (RSP_EXPECT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .TIMEOUT    (TIMEOUT),
    .CRC_ERR    (CRC_ERR),
    .RSP_INDEX  (RSP_INDEX),
    .RSP_ARG    (RSP_ARG),
    .CMD_O      (CMD_O),
    .CMD_OE     (CMD_OE),
    .CMD_I      (CMD_I)
  );

  localparam int TURN_N = 2;
  localparam int TO_N   = 64;

  int n_cmp = 0;
  int n_fail = 0;

  int sd_div = 1;
  int div_cnt = 0;
  bit sd_stop = 0;

  bit rsp_on = 0;
  bit rsp_armed = 0;
  int rsp_dly = 0;
  int fcnt = 0;
  logic [47:0] rsp_word = '0;

  logic [47:0] exp_frame = '0;
  bit exp_rsp = 0;
  bit exp_to = 0;
  bit exp_crc = 0;
  logic [5:0] exp_idx = '0;
  logic [31:0] exp_arg = '0;
  int exp_rises = 0;

  logic [47:0] cap = '0;
  int ncap = 0;
  int rcnt = 0;
  int done_cnt = 0;
  bit sd_prev = 0;
  bit oe_prev = 0;
  bit rise_s;
  bit rel_s;

  logic [47:0] rsp_w;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // SD clock source and card responder (card drives on falls)
  always @(posedge CLK) begin
    #1;
    if (!sd_stop) begin
      if (div_cnt >= sd_div - 1) begin
        div_cnt = 0;
        SD_CLK = ~SD_CLK;
        if (!SD_CLK && rsp_armed) begin
          fcnt++;
          if (fcnt >= rsp_dly && fcnt < rsp_dly + 48)
            CMD_I = rsp_word[47 - (fcnt - rsp_dly)];
          else
            CMD_I = 1'b1;
        end
      end else begin
        div_cnt++;
      end
    end
  end

  // per-cycle monitor: frame capture, release, completion
  always @(negedge CLK) begin
    rise_s = SD_CLK && !sd_prev;
    sd_prev = SD_CLK;
    rel_s = 0;
    if (!RST_N) begin
      oe_prev = 0;
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_to", TIMEOUT, 0);
      chk("rst_crc", CRC_ERR, 0);
      chk("rst_idx", RSP_INDEX, 0);
      chk("rst_arg", RSP_ARG, 0);
      chk("rst_cmd_o", CMD_O, 1);
      chk("rst_oe", CMD_OE, 0);
    end else begin
      if (oe_prev && !CMD_OE) begin
        rel_s = 1;
        chk("frame", cap, exp_frame);
        chk("frame_bits", ncap, 48);
        rcnt = 0;
        if (rsp_on) begin
          fcnt = 0;
          rsp_armed = 1;
        end
      end
      if (rise_s) begin
        rcnt++;
        if (CMD_OE) begin
          cap = {cap[46:0], CMD_O};
          ncap++;
        end
      end
      if (DONE) begin
        done_cnt++;
        chk("done_busy", BUSY, 1);
        chk("timeout", TIMEOUT, exp_to);
        chk("crc_err", CRC_ERR, exp_crc);
        chk("rsp_index", RSP_INDEX, exp_idx);
        chk("rsp_arg", RSP_ARG, exp_arg);
        chk("done_oe", CMD_OE, 0);
        if (exp_rsp) chk("done_rises", rcnt, exp_rises);
        else chk("done_at_release", rel_s, 1);
      end
      if (!BUSY) begin
        chk("idle_oe", CMD_OE, 0);
        chk("idle_cmd_o", CMD_O, 1);
        chk("idle_done", DONE, 0);
      end
      oe_prev = CMD_OE;
    end
  end

  // opt[0]: stall SD_CLK mid-frame
  // opt[1]: extra START while busy
  // opt[2]: async reset during bit 20
  task automatic run_cmd(input string nm,
                         input logic [5:0] idx,
                         input logic [31:0] arg,
                         input bit rsp,
                         input bit reply,
                         input int dly,
                         input logic [47:0] word,
                         input logic [47:0] lit,
                         input bit use_lit,
                         input logic [2:0] opt);
    logic [39:0] d40;
    int base;
    int n0;
    int i;
    d40 = {2'b01, idx, arg};
    exp_frame = {d40, crc7(d40), 1'b1};
    exp_rsp = rsp;
    exp_to = 0;
    exp_crc = 0;
    exp_idx = '0;
    exp_arg = '0;
    exp_rises = 0;
    if (rsp && !reply) begin
      exp_to = 1;
      exp_rises = TURN_N + TO_N;
    end else if (rsp) begin
      exp_idx = word[45:40];
      exp_arg = word[39:8];
      exp_crc = ~word[0];
`ifdef SD_CMD_RSP_CRC_CHECK_EN
      if (crc7(word[47:8]) != word[7:1]) exp_crc = 1;
`endif
      exp_rises = dly + 48;
    end
    rsp_on = reply;
    rsp_dly = dly;
    rsp_word = word;
    rsp_armed = 0;
    base = done_cnt;
    @(negedge CLK);
    CMD_INDEX = idx;
    CMD_ARG = arg;
    RSP_EXPECT = rsp;
    cap = '0;
    ncap = 0;
    START = 1;
    @(negedge CLK);
    START = 0;
    chk({nm, "_busy_set"}, BUSY, 1);
    if (opt[0]) begin
      for (i = 0; i < 2000 && ncap < 10; i++) @(negedge CLK);
      sd_stop = 1;
      n0 = ncap;
      repeat (40) @(negedge CLK);
      chk({nm, "_stall_bits"}, ncap, n0);
      chk({nm, "_stall_oe"}, CMD_OE, 1);
      chk({nm, "_stall_busy"}, BUSY, 1);
      sd_stop = 0;
    end
    if (opt[1]) begin
      repeat (6) @(negedge CLK);
      CMD_INDEX = ~idx;
      CMD_ARG = ~arg;
      RSP_EXPECT = ~rsp;
      START = 1;
      @(negedge CLK);
      START = 0;
    end
    if (opt[2]) begin
      for (i = 0; i < 2000 && ncap < 20; i++) @(negedge CLK);
      chk({nm, "_reached_bit20"}, ncap, 20);
      #2 RST_N = 0;
      #1;
      chk({nm, "_rst_oe"}, CMD_OE, 0);
      chk({nm, "_rst_busy"}, BUSY, 0);
      chk({nm, "_rst_cmd_o"}, CMD_O, 1);
      repeat (3) @(negedge CLK);
      #2 RST_N = 1;
      rsp_armed = 0;
      repeat (3) @(negedge CLK);
      return;
    end
    for (i = 0; i < 4000 && done_cnt == base; i++)
      @(negedge CLK);
    chk({nm, "_done_count"}, done_cnt - base, 1);
    if (use_lit) chk({nm, "_lit_frame"}, cap, lit);
    @(negedge CLK);
    chk({nm, "_busy_drop"}, BUSY, 0);
    rsp_armed = 0;
    if (opt[1]) begin
      repeat (10) @(negedge CLK);
      chk({nm, "_no_queue"}, BUSY, 0);
      chk({nm, "_no_queue_n"}, done_cnt - base, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    SD_CLK = 0;
    START = 0;
    CMD_INDEX = '0;
    CMD_ARG = '0;
    RSP_EXPECT = 0;
    CMD_I = 1;
    RST_N = 1;
    #1 RST_N = 0;
    repeat (3) @(negedge CLK);
    #2 RST_N = 1;
    repeat (2) @(negedge CLK);

    sd_div = 1;
    run_cmd("cmd0", 6'd0, 32'h0, 0, 0, 0, '0,
            48'h40_0000_0000_95, 1, 3'b000);

    sd_div = 3;
    run_cmd("cmd17", 6'd17, 32'h0, 0, 0, 0, '0,
            48'h51_0000_0000_55, 1, 3'b001);

    sd_div = 1;
    run_cmd("cmd8", 6'd8, 32'h1AA, 1, 1, 5,
            48'h08_0000_01AA_13,
            48'h48_0000_01AA_87, 1, 3'b010);
    chk("cmd8_idx_lit", RSP_INDEX, 6'd8);
    chk("cmd8_arg_lit", RSP_ARG, 32'h1AA);
    chk("cmd8_crc_lit", CRC_ERR, 0);
    repeat (5) @(negedge CLK);
    chk("cmd8_idx_held", RSP_INDEX, 6'd8);

    run_cmd("cmd55_to", 6'd55, 32'h0, 1, 0, 0, '0,
            '0, 0, 3'b000);
    chk("to_lit", TIMEOUT, 1);

    run_cmd("crc_bad", 6'd8, 32'h1AA, 1, 1, 5,
            48'h08_0000_01AA_15,
            48'h48_0000_01AA_87, 1, 3'b000);

    run_cmd("end_bad", 6'd8, 32'h1AA, 1, 1, 5,
            48'h08_0000_01AA_12,
            48'h48_0000_01AA_87, 1, 3'b000);
    chk("end_bad_lit", CRC_ERR, 1);

    rsp_w[47:8] = {2'b00, 6'd13, 32'h0000_0900};
    rsp_w[7:1] = crc7(rsp_w[47:8]);
    rsp_w[0] = 1'b1;

    sd_div = 2;
    run_cmd("cmd13_early", 6'd13, 32'hDEAD_BEEF, 1, 1,
            TURN_N, rsp_w, '0, 0, 3'b000);
    chk("cmd13_crc_lit", CRC_ERR, 0);

    run_cmd("cmd13_late", 6'd13, 32'h0001_0000, 1, 1,
            TURN_N + TO_N - 1, rsp_w, '0, 0, 3'b000);
    chk("late_to_lit", TIMEOUT, 0);

    sd_div = 1;
    run_cmd("rst_mid", 6'd17, 32'h1234_5678, 0, 0, 0,
            '0, '0, 0, 3'b100);
    run_cmd("after_rst", 6'd17, 32'h1234_5678, 0, 0, 0,
            '0, '0, 0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
